imem_loader: RTL
================

# imem_loader

Boot-time programmer for the instruction memory. Receives a byte stream (word count header, little-endian instruction words, XOR checksum), writes each assembled word into the instruction memory write port at consecutive word addresses from `BASE_PC`, and holds the CPU until a load completes with a valid checksum. It sits between the host link (UART/debug byte stream) and the instruction memory, alongside the core's reset logic.

## Interface
- `BASE_PC`, 32'h0000_0000, byte address of instruction word 0; first write address.
- `DEPTH_WORDS`, 512, instruction memory capacity in words; largest legal count.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a load; honoured in IDLE, DONE, ERR only.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; transfer when `rx_valid && rx_ready`.
- `we`  out  1  one-cycle instruction memory write strobe.
- `waddr`  out  32  byte address of the write, `BASE_PC + 4*index`.
- `wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the core in reset/stall while high.
- `done`  out  1  load completed with a good checksum.
- `error`  out  1  load aborted: bad count or checksum mismatch.
- `words_loaded`  out  $clog2(DEPTH_WORDS+1)  words written in the current or last load.

## Operation
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE: `rx_ready`=0. `start` clears the count, index, checksum accumulator, `words_loaded`, `done` and `error`, then enters HDR.
- HDR: accept 4 bytes into a 32-bit count, little-endian with the first byte as LSB. After the 4th byte, count==0 or count>DEPTH_WORDS goes to ERR; otherwise go to DATA.
- DATA: accept bytes and assemble them little-endian. XOR every data byte into an 8-bit accumulator.
  - On each 4th byte, register `wdata`, `waddr` = BASE_PC + (index<<2) (32-bit wrap-around arithmetic), pulse `we`, increment index and `words_loaded`.
  - After word number count, go to CSUM.
- CSUM: accept 1 byte. If it equals the accumulator, go to DONE; otherwise go to ERR. Header bytes are excluded from the checksum.
- DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0.
- ERR: `error`=1, `cpu_hold`=1, `rx_ready`=0. Words already written stay in memory.
- `rx_ready`=1 in HDR, DATA and CSUM. Bytes offered in other states are not consumed.
- `start` is ignored in HDR, DATA and CSUM. From DONE, `start` raises `cpu_hold` again.
- Idle cycles (`rx_valid`=0) mid-word or mid-header stall without losing partial state.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0.
- `start` at cycle t: `rx_ready`=1 at t+1.
- Throughput is 1 byte/cycle with no bubbles, including across word boundaries and during `we` cycles.
- 4th byte of a word accepted at cycle t: `we`/`waddr`/`wdata` valid at t+1 only. `words_loaded` updates at t+1.
- 4th header byte or last data byte accepted at t: the new state is visible at t+1, with `rx_ready` matching that state.
- Checksum byte accepted at t: `done`/`cpu_hold`=0 or `error` at t+1.
- All outputs are registered. Reset asserted mid-load returns to reset values immediately and asynchronously, and any pending `we` is dropped.

## Structure
- Package `imem_loader_pkg`:
  - state enum `loader_state_t`
  - `HDR_BYTES`=4
  - `NOP_INSTR`=32'h0000_0013, shared with the instruction memory.
- Sub-module `byte_packer`: 4-byte little-endian shift/assembly with a byte counter and a `word_valid` pulse. It is used for both the header and the data words.

## Test plan
- Reset: all outputs at their reset values and `cpu_hold`=1. `rx_valid`=1 with no `start` gives `rx_ready`=0.
- Good load: start, header 02 00 00 00, data 13 00 00 00 93 00 10 00, checksum 90 → two `we` pulses with (0x0, 0x00000013) and (0x4, 0x00100093). `done`=1 and `cpu_hold`=0 the cycle after the checksum byte is accepted. `words_loaded`=2.
- Bad checksum: same stream with checksum 91 → both words written, `error`=1, `cpu_hold`=1, `rx_ready`=0.
- Bad count: header 01 02 00 00 (513) and, separately, header 00 00 00 00 → ERR after the 4th byte, `we` never asserted.
- Gaps and BASE_PC: BASE_PC=32'h8000_0000, `rx_valid` toggled randomly, 3-word load → `waddr` 0x8000_0000/04/08 and correct data; the second load after `start` from DONE re-raises `cpu_hold` and succeeds.
- Async reset mid-DATA after 5 bytes → immediate reset values. A following `start` and full load succeeds with `words_loaded` counting from 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Header/word framing is little-endian; checksum is an 8-bit XOR over data bytes.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   localparam int          HDR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic count_ok(input logic [31:0] cnt, input logic [31:0] depth);
      return (cnt != 32'd0) && (cnt <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in (valid/ready), imem write port and boot status out.
// master = loader side, slave = host/memory/core side.
interface imem_loader_if #(
   parameter int DEPTH_WORDS = 512
) ();
   localparam int WL_W = $clog2(DEPTH_WORDS + 1);

   logic            start;
   logic [7:0]      rx_data;
   logic            rx_valid;
   logic            rx_ready;
   logic            we;
   logic [31:0]     waddr;
   logic [31:0]     wdata;
   logic            cpu_hold;
   logic            done;
   logic            error;
   logic [WL_W-1:0] words_loaded;

   modport master (
      input  start, rx_data, rx_valid,
      output rx_ready, we, waddr, wdata, cpu_hold, done, error, words_loaded
   );

   modport slave (
      output start, rx_data, rx_valid,
      input  rx_ready, we, waddr, wdata, cpu_hold, done, error, words_loaded
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs 4 bytes little-endian into a word; word_valid is combinational with the 4th byte.
// No backpressure of its own: the caller gates byte_valid with its handshake.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word_data
);
   localparam int CNT_W = $clog2(HDR_BYTES);
   localparam int SH_W  = 8 * (HDR_BYTES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SH_W-1:0]  sh_q, sh_d;

   // Bytes enter at the top and shift down, so the first byte ends up as the LSB.
   always_comb begin
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      word_valid = 1'b0;
      word_data  = {byte_data, sh_q};
      if (clr) begin
         cnt_d = '0;
      end else if (byte_valid) begin
         sh_d = {byte_data, sh_q[SH_W-1:8]};
         if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
            word_valid = 1'b1;
            cnt_d      = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: count header, LE words to imem from BASE_PC, XOR checksum; holds CPU until good.
// 1 byte/cycle, write strobe one cycle after a word's 4th byte; rx_ready low outside HDR/DATA/CSUM.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_PC     = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 512
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.master bus
);
   localparam int WL_W = $clog2(DEPTH_WORDS + 1);

   loader_state_t   state_q, state_d;
   logic [WL_W-1:0] cnt_q, cnt_d;
   logic [WL_W-1:0] idx_q, idx_d;
   logic [7:0]      csum_q, csum_d;
   logic            rx_ready_q, rx_ready_d;
   logic            we_q, we_d;
   logic [31:0]     waddr_q, waddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            xfer;
   logic            pk_valid;
   logic            pk_clr;
   logic            word_valid;
   logic [31:0]     word_data;

   assign xfer     = bus.rx_valid && rx_ready_q;
   assign pk_valid = xfer && ((state_q == ST_HDR) || (state_q == ST_DATA));
   assign pk_clr   = bus.start &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (pk_clr),
      .byte_valid (pk_valid),
      .byte_data  (bus.rx_data),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      csum_d     = csum_q;
      rx_ready_d = rx_ready_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start) begin
               state_d    = ST_HDR;
               cnt_d      = '0;
               idx_d      = '0;
               csum_d     = '0;
               rx_ready_d = 1'b1;
               cpu_hold_d = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
            end
         end
         ST_HDR: begin
            if (word_valid) begin
               if (count_ok(word_data, 32'(DEPTH_WORDS))) begin
                  cnt_d   = word_data[WL_W-1:0];
                  state_d = ST_DATA;
               end else begin
                  state_d    = ST_ERR;
                  error_d    = 1'b1;
                  rx_ready_d = 1'b0;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               csum_d = csum_q ^ bus.rx_data;
            end
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = BASE_PC + (32'(idx_q) << 2);
               wdata_d = word_data;
               idx_d   = idx_q + WL_W'(1);
               if (idx_d == cnt_q) begin
                  state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               rx_ready_d = 1'b0;
               if (bus.rx_data == csum_q) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
               end else begin
                  state_d = ST_ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            rx_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         csum_q     <= '0;
         rx_ready_q <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         rx_ready_q <= rx_ready_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.rx_ready     = rx_ready_q;
   assign bus.we           = we_q;
   assign bus.waddr        = waddr_q;
   assign bus.wdata        = wdata_q;
   assign bus.cpu_hold     = cpu_hold_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.words_loaded = idx_q;

endmodule
